// File: rtl/mul_controller_pkg.sv
// Shared constants and FSM state encoding for the repeated-addition multiplier controller.
// DATA_W is the operand/result width the datapath is built with.
package mul_controller_pkg;

  localparam int DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    LOAD_B = 3'd2,
    ACCUM  = 3'd3,
    DONE   = 3'd4,
    ERR    = 3'd5
  } state_t;

endpackage

// File: rtl/mul_controller_if.sv
// Controller-facing handshake and datapath-control bundle; master = controller, slave = host/datapath side.
interface mul_controller_if;

  logic start;
  logic in_valid;
  logic in_ready;
  logic eqz;
  logic res_ack;
  logic ldA;
  logic ldB;
  logic ldP;
  logic decB;
  logic clrP;
  logic done;
  logic busy;
  logic error;

  modport master (
    input  start, in_valid, eqz, res_ack,
    output in_ready, ldA, ldB, ldP, decB, clrP, done, busy, error
  );

  modport slave (
    output start, in_valid, eqz, res_ack,
    input  in_ready, ldA, ldB, ldP, decB, clrP, done, busy, error
  );

endinterface

// File: rtl/mul_controller_iter_counter.sv
// Accumulate-cycle counter: sync clear, enable, terminal-count flag; present only with MUL_CTRL_TIMEOUT_EN.
// Zero latency on tc (combinational compare of the registered count); no backpressure.
`ifdef MUL_CTRL_TIMEOUT_EN
module mul_controller_iter_counter #(
  parameter int WIDTH    = 17,
  parameter int TERMINAL = 65536
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic tc
);

  localparam logic [WIDTH-1:0] TC_VAL = WIDTH'(TERMINAL);

  logic [WIDTH-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset)       count <= '0;
    else if (clear)  count <= '0;
    else if (enable) count <= count + 1'b1;
  end

  assign tc = (count == TC_VAL);

endmodule
`endif

// File: rtl/mul_controller.sv
// Sequencer for the P += A / B-- multiplier datapath; operands via valid/ready, done held until res_ack.
// Optional MUL_CTRL_TIMEOUT_EN adds an ERR abort after MAX_ITER accumulate cycles.
module mul_controller
  import mul_controller_pkg::*;
#(
  parameter int ITER_W   = 17,
  parameter int MAX_ITER = 65536
) (
  input  logic            clock,
  input  logic            reset,
  mul_controller_if.master bus
);

  if (ITER_W < $clog2(MAX_ITER + 1)) begin : g_iter_w_check
    $error("ITER_W too narrow to hold MAX_ITER");
  end

  state_t state, state_nxt;
  logic   in_ready, ld_a, ld_b, ld_p, dec_b, clr_p, done_flag, err_flag;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

`ifdef MUL_CTRL_TIMEOUT_EN
  logic iter_tc;

  mul_controller_iter_counter #(
    .WIDTH    (ITER_W),
    .TERMINAL (MAX_ITER)
  ) u_iter (
    .clock  (clock),
    .reset  (reset),
    .clear  (ld_b),
    .enable (ld_p),
    .tc     (iter_tc)
  );
`endif

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    ld_p      = 1'b0;
    dec_b     = 1'b0;
    clr_p     = 1'b0;
    done_flag = 1'b0;
    err_flag  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) state_nxt = LOAD_A;
      end
      LOAD_A: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          ld_a      = 1'b1;
          clr_p     = 1'b1;
          state_nxt = LOAD_B;
        end
      end
      LOAD_B: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          ld_b      = 1'b1;
          state_nxt = ACCUM;
        end
      end
      ACCUM: begin
        // eqz wins over the timeout so a B that reaches zero on the limit still completes
        if (bus.eqz) state_nxt = DONE;
`ifdef MUL_CTRL_TIMEOUT_EN
        else if (iter_tc) state_nxt = ERR;
`endif
        else begin
          ld_p  = 1'b1;
          dec_b = 1'b1;
        end
      end
      DONE: begin
        done_flag = 1'b1;
        if (bus.res_ack) state_nxt = IDLE;
      end
`ifdef MUL_CTRL_TIMEOUT_EN
      ERR: begin
        err_flag = 1'b1;
        if (bus.res_ack) state_nxt = IDLE;
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.in_ready = in_ready;
  assign bus.ldA      = ld_a;
  assign bus.ldB      = ld_b;
  assign bus.ldP      = ld_p;
  assign bus.decB     = dec_b;
  assign bus.clrP     = clr_p;
  assign bus.done     = done_flag;
  assign bus.error    = err_flag;
  assign bus.busy     = (state != IDLE);

endmodule
